// File: rtl/flattening_buffer.sv
// flattening_buffer
//   Collects ImageSize consecutive beats from Channels parallel pixel streams
//   into one flattened frame vector. Two banks ping-pong, so the next frame
//   fills while the previous one waits for the consumer.
//
//   Optional build macro: FLAT_ORDER_REVERSE_EN
//     undefined : first sample of a frame lands at index ImageSize-1
//     defined   : first sample of a frame lands at index 0
//
//   Ports
//     clk        clock, rising edge
//     res_n      synchronous reset, ACTIVE HIGH (name kept for compatibility)
//     in_valid   input beat valid
//     in_ready   block can accept a beat
//     in_data    [Channels][BitSize] one pixel per channel
//     out_valid  flattened frame available
//     out_ready  consumer accepts frame
//     out_data   [Channels][ImageSize][BitSize] flattened frame (0 when idle)
//     out_done   one-cycle pulse per completed frame

// Per-channel storage: both banks of one channel plus its read mux.
module flattening_lane #(
    parameter int BitSize   = 2,
    parameter int ImageSize = 9,
    parameter int PW        = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic                              wr_bank,
    input  logic [PW-1:0]                     wr_idx,
    input  logic [BitSize-1:0]                din,
    input  logic                              rd_bank,
    input  logic                              rd_en,
    output logic [ImageSize-1:0][BitSize-1:0] dout
);
    logic [1:0][ImageSize-1:0][BitSize-1:0] bank;

    always_ff @(posedge clk) begin
        if (rst)        bank <= '0;
        else if (wr_en) bank[wr_bank][wr_idx] <= din;
    end

    assign dout = rd_en ? bank[rd_bank] : '0;
endmodule

module flattening_buffer #(
    parameter int BitSize   = 2,
    parameter int ImageSize = 9,
    parameter int Channels  = 4,
    parameter int Delay     = 0
) (
    input  logic                                            clk,
    input  logic                                            res_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [Channels-1:0][BitSize-1:0]                in_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [Channels-1:0][ImageSize-1:0][BitSize-1:0] out_data,
    output logic                                            out_done
);
    localparam int PW = (ImageSize > 1) ? $clog2(ImageSize) : 1;
    localparam int SW = (Delay > 0) ? $clog2(Delay + 1) : 1;

    localparam logic [1:0] SKIP  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] pix_cnt;
    logic [SW-1:0] skip_cnt;
    logic          wr_bank, rd_bank;
    logic [1:0]    full, full_nxt;
    logic          done_q;
    logic          acc, hs, fill_acc, last;
    logic [PW-1:0] wr_idx;

    // Reset gating keeps the outputs quiet during the reset cycle itself,
    // before the registers have been cleared.
    assign in_ready  = !res_n && (state != STALL);
    assign out_valid = !res_n && full[rd_bank];
    assign out_done  = !res_n && done_q;

    assign acc      = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign fill_acc = acc && (state == FILL);
    assign last     = fill_acc && (pix_cnt == PW'(ImageSize - 1));

`ifdef FLAT_ORDER_REVERSE_EN
    assign wr_idx = pix_cnt;
`else
    assign wr_idx = PW'(ImageSize - 1) - pix_cnt;
`endif

    // Full flags after this cycle's events. A completing write and a read
    // handshake always target different banks (the write bank is never full
    // while filling, the read bank always is), so both updates apply.
    always_comb begin
        full_nxt = full;
        if (hs)   full_nxt[rd_bank] = 1'b0;
        if (last) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res_n) begin
            state    <= (Delay > 0) ? SKIP : FILL;
            pix_cnt  <= '0;
            skip_cnt <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= '0;
            done_q   <= 1'b0;
        end else begin
            full   <= full_nxt;
            done_q <= last;
            if (hs) rd_bank <= !rd_bank;
            case (state)
                SKIP: if (acc) begin
                    skip_cnt <= skip_cnt + 1'b1;
                    if (int'(skip_cnt) == Delay - 1) state <= FILL;
                end
                FILL: if (acc) begin
                    if (last) begin
                        pix_cnt <= '0;
                        wr_bank <= !wr_bank;
                        // Stall only if the bank we move to still holds an
                        // unconsumed frame after this cycle's handshake.
                        state   <= full_nxt[!wr_bank] ? STALL : FILL;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                STALL: if (!full_nxt[wr_bank]) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    for (genvar c = 0; c < Channels; c++) begin : g_lane
        flattening_lane #(
            .BitSize  (BitSize),
            .ImageSize(ImageSize),
            .PW       (PW)
        ) u_lane (
            .clk    (clk),
            .rst    (res_n),
            .wr_en  (fill_acc),
            .wr_bank(wr_bank),
            .wr_idx (wr_idx),
            .din    (in_data[c]),
            .rd_bank(rd_bank),
            .rd_en  (out_valid),
            .dout   (out_data[c])
        );
    end
endmodule

// File: doc/flattening_buffer.md
Name: flattening_buffer

Overview:
- Multi-channel successor to the single-channel flattening PE.
- Collects ImageSize consecutive beats from Channels parallel pixel streams into one flattened frame vector for the dense/fully-connected stage.
- Ping-pong banked, so the next frame fills while the previous one is held.
- Adds a valid/ready handshake on both sides, per-frame done pulses and backpressure. The single-channel PE has none of these.

Parameters:
- BitSize, 2, bits per pixel.
- ImageSize, 9, pixels per channel per frame; must be ≥1.
- Channels, 4, parallel input channels; must be ≥1.
- Delay, 0, accepted beats discarded once after reset for pipeline priming; must be ≥0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- res_n  in  1  reset. Synchronous and active-high: asserted = 1, despite the codebase port name.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  [Channels-1:0][BitSize-1:0]  one pixel per channel.
- out_valid  out  1  flattened frame available.
- out_ready  in  1  consumer accepts frame.
- out_data  out  [Channels-1:0][ImageSize-1:0][BitSize-1:0]  flattened frame.
- out_done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Beat accepted when in_valid && in_ready. Frame consumed when out_valid && out_ready.
- Storage and state:
  - Two banks, each [Channels][ImageSize][BitSize], plus a full flag per bank.
  - Pointers wr_bank and rd_bank.
  - pix_cnt: $clog2(ImageSize), minimum 1 bit.
  - skip_cnt: $clog2(Delay+1), minimum 1 bit.
- Reset (res_n=1 at posedge):
  - Counters, pointers and full flags cleared; banks cleared to 0.
  - out_valid=0, out_done=0, in_ready=0 while res_n is high.
  - Mid-frame reset discards the partial frame and both banks, and restarts the skip phase.
- Write FSM states: SKIP, FILL, STALL.
  - After reset: SKIP if Delay>0, else FILL.
  - SKIP: in_ready=1. Accepted beats discarded; skip_cnt increments. After the Delay-th accepted beat → FILL. Never re-entered until the next reset.
  - FILL: in_ready=1. Accepted beat writes in_data[c] to bank[wr_bank][c][ImageSize-1-pix_cnt] for every c, so the first sample lands in the highest index. pix_cnt increments.
  - Frame complete (pix_cnt==ImageSize-1 on accept): full[wr_bank] set, wr_bank toggles, pix_cnt→0, out_done=1 next cycle for exactly one cycle.
  - After completion: next state STALL if the new wr_bank is still full, else FILL.
  - STALL: in_ready=0. Returns to FILL the cycle after its bank is freed.
- in_ready is combinational from registered state only; it never depends on in_valid.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank] when out_valid, else all-zero.
  - On handshake: full[rd_bank] cleared, rd_bank toggles.
  - out_data must be stable while out_valid && !out_ready.
- Latency: last beat accepted in cycle N → out_valid and out_done high in N+1 (read bank empty case). Zero bubbles between frames when out_ready=1.
- Simultaneous events:
  - Frame completion plus read handshake in the same cycle: both take effect, no frame lost or duplicated.
  - Handshake freeing the bank the FSM is stalled on: in_ready rises next cycle.
- ImageSize=1: every accepted beat completes a frame.

Optional Feature:
- Macro FLAT_ORDER_REVERSE_EN.
- Defined: write index = pix_cnt, so the first sample lands at index 0.
- Undefined: index ImageSize-1-pix_cnt (default, legacy ordering).
- Nothing else changes.

Test Plan:
- Channels=2, ImageSize=4, Delay=0, out_ready=1; beats ch0=1,2,3,0 and ch1=3,2,1,0 → next cycle out_valid=1, out_done pulses once, out_data[0][3:0]=1,2,3,0 (index3..0), out_data[1][3:0]=3,2,1,0.
- Delay=2; beats ch0=3,3 then 1,2,3,0 → the 3s are discarded; frame identical to scenario 1; out_done only after the 6th beat.
- out_ready=0, 12 continuous beats (3 frames) → frames 1 and 2 stored; in_ready=0 after the 8th accept; frame1 held stable. One-cycle out_ready → frame2 presented next cycle, in_ready=1, frame3 accepted.
- out_ready asserted in the same cycle as the last beat of frame 2 → frame1 consumed, frame2 presented the next cycle, no stall, no loss.
- res_n pulse after 2 beats of a frame → out_valid=0, in_ready=0 during reset. The next 4 beats (plus Delay skip) form a clean frame with no stale data.
- FLAT_ORDER_REVERSE_EN defined, scenario 1 stimulus → out_data[0][0]=1, [1]=2, [2]=3, [3]=0.
